eth_gmii_frame_tx: RTL and testbench

ETH_GMII_FRAME_TX -- requirements
Module: eth_gmii_frame_tx

---
 rtl/eth_gmii_frame_tx.sv | 177 +++++++++++++++++
 tb/tb_eth_gmii_frame_tx.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/eth_gmii_frame_tx.sv
// GMII Ethernet frame transmitter: preamble/SFD, header, payload with optional
// zero padding, CRC-32 FCS and inter-frame gap, with underrun/overlength abort.
module eth_gmii_frame_tx #(
  parameter int IFG_BYTES   = 12,
  parameter int MIN_PAYLOAD = 46,
  parameter int MAX_PAYLOAD = 1500,
  parameter bit PAD_EN      = 1'b1
) (
  input  logic        gmii_tx_clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [47:0] dst_mac,
  input  logic [47:0] src_mac,
  input  logic [15:0] eth_type,
  input  logic [7:0]  pl_data,
  input  logic        pl_valid,
  input  logic        pl_last,
  output logic        pl_ready,
  output logic        gmii_tx_en,
  output logic        gmii_tx_er,
  output logic [7:0]  gmii_tx_data,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        phy_rst_n
);

  typedef enum logic [2:0] {IDLE, PRE, SFD, HDR, PAY, PAD, FCS, IFG} state_t;

  localparam logic [10:0] MAX_CNT  = 11'(MAX_PAYLOAD);
  localparam logic [10:0] MIN_CNT  = 11'(MIN_PAYLOAD);
  localparam logic [7:0]  IFG_LAST = 8'(IFG_BYTES - 1);

  // The state names the phase of the byte driven at the next clock edge,
  // so pl_ready can be registered without a gap between header and payload.
  state_t        state;
  logic [7:0]    cnt;
  logic [10:0]   pl_cnt;
  logic [10:0]   pl_cnt_inc;
  logic [111:0]  hdr;
  logic [31:0]   crc;
  logic          aborted;
  logic          phy_meta;

  assign pl_cnt_inc = pl_cnt + 11'd1;

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'd0, d};
    for (int i = 0; i < 8; i++)
      r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
    return r;
  endfunction

  always_ff @(posedge gmii_tx_clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // branch below reads the values from before this clock edge.
      state        <= IDLE;
      cnt          <= '0;
      pl_cnt       <= '0;
      hdr          <= '0;
      crc          <= '0;
      aborted      <= 1'b0;
      pl_ready     <= 1'b0;
      gmii_tx_en   <= 1'b0;
      gmii_tx_er   <= 1'b0;
      gmii_tx_data <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
    end else begin
      done       <= 1'b0;
      err        <= 1'b0;
      gmii_tx_er <= 1'b0;
      case (state)
        IDLE: begin
          gmii_tx_en   <= 1'b0;
          gmii_tx_data <= '0;
          if (busy) begin
            busy <= 1'b0;
          end else if (start) begin
            busy         <= 1'b1;
            hdr          <= {dst_mac, src_mac, eth_type};
            crc          <= 32'hFFFF_FFFF;
            pl_cnt       <= '0;
            cnt          <= 8'd1;
            aborted      <= 1'b0;
            gmii_tx_en   <= 1'b1;
            gmii_tx_data <= 8'h55;
            state        <= PRE;
          end
        end
        PRE: begin
          gmii_tx_data <= 8'h55;
          if (cnt == 8'd6) state <= SFD;
          else             cnt   <= cnt + 8'd1;
        end
        SFD: begin
          gmii_tx_data <= 8'hD5;
          cnt          <= '0;
          state        <= HDR;
        end
        HDR: begin
          gmii_tx_data <= hdr[111:104];
          hdr          <= hdr << 8;
          crc          <= crc_byte(crc, hdr[111:104]);
          if (cnt == 8'd13) begin
            state    <= PAY;
            pl_ready <= (MAX_CNT != 11'd0);
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        PAY: begin
          if (pl_ready && pl_valid) begin
            gmii_tx_data <= pl_data;
            crc          <= crc_byte(crc, pl_data);
            pl_cnt       <= pl_cnt_inc;
            if (pl_last) begin
              pl_ready <= 1'b0;
              cnt      <= '0;
              state    <= (PAD_EN && (pl_cnt_inc < MIN_CNT)) ? PAD : FCS;
            end else begin
              pl_ready <= (pl_cnt_inc < MAX_CNT);
            end
          end else begin
            // Underrun, or MAX_PAYLOAD reached without pl_last: poison one byte.
            gmii_tx_er   <= 1'b1;
            gmii_tx_data <= '0;
            pl_ready     <= 1'b0;
            err          <= 1'b1;
            aborted      <= 1'b1;
            cnt          <= '0;
            state        <= IFG;
          end
        end
        PAD: begin
          gmii_tx_data <= '0;
          crc          <= crc_byte(crc, 8'h00);
          pl_cnt       <= pl_cnt_inc;
          if (pl_cnt_inc >= MIN_CNT) begin
            cnt   <= '0;
            state <= FCS;
          end
        end
        FCS: begin
          gmii_tx_data <= ~crc[{cnt[1:0], 3'b000} +: 8];
          if (cnt == 8'd3) begin
            cnt   <= '0;
            state <= IFG;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        IFG: begin
          gmii_tx_en   <= 1'b0;
          gmii_tx_data <= '0;
          if (cnt == IFG_LAST) begin
            done  <= ~aborted;
            cnt   <= '0;
            state <= IDLE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge gmii_tx_clk or negedge rst_n) begin
    if (!rst_n) {phy_rst_n, phy_meta} <= 2'b00;
    else        {phy_rst_n, phy_meta} <= {phy_meta, 1'b1};
  end

endmodule

// File: tb/tb_eth_gmii_frame_tx.sv
// Self-checking bench for eth_gmii_frame_tx: random frames compared against a
// byte-level frame model with a table-driven CRC-32.
module tb_eth_gmii_frame_tx;
  localparam int IFG  = 12;
  localparam int MINP = 46;
  localparam int MAXP = 1500;

  logic        clk = 1'b0;
  logic        rst_n, start, pl_valid, pl_last;
  logic [47:0] dst_mac, src_mac;
  logic [15:0] eth_type;
  logic [7:0]  pl_data;
  logic        pl_ready, gmii_tx_en, gmii_tx_er, busy, done, err, phy_rst_n;
  logic [7:0]  gmii_tx_data;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  logic [31:0] crc_tbl [256];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  eth_gmii_frame_tx #(.IFG_BYTES(IFG), .MIN_PAYLOAD(MINP), .MAX_PAYLOAD(MAXP), .PAD_EN(1'b1)) dut (
    .gmii_tx_clk(clk), .rst_n(rst_n), .start(start), .dst_mac(dst_mac), .src_mac(src_mac),
    .eth_type(eth_type), .pl_data(pl_data), .pl_valid(pl_valid), .pl_last(pl_last),
    .pl_ready(pl_ready), .gmii_tx_en(gmii_tx_en), .gmii_tx_er(gmii_tx_er),
    .gmii_tx_data(gmii_tx_data), .busy(busy), .done(done), .err(err), .phy_rst_n(phy_rst_n)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
    return (c >> 8) ^ crc_tbl[c[7:0] ^ b];
  endfunction

  function automatic logic [7:0] all_outs();
    return {gmii_tx_en, gmii_tx_er, |gmii_tx_data, pl_ready, busy, done, err, phy_rst_n};
  endfunction

  // Sends one frame and checks the wire against the model. drop_at<0: no drop.
  task automatic run_frame(input string name, input logic [47:0] d, input logic [47:0] s,
                           input logic [15:0] ty, input int n, input bit last_flag,
                           input int drop_at, input bit incr_data);
    logic [7:0]   payload[$];
    logic [7:0]   exp_q[$];
    logic [7:0]   got_q[$];
    bit           got_er[$];
    logic [111:0] h;
    logic [31:0]  c, rr;
    int pay_sent, er_idx, idx, xfers, first_en, last_en, done_cyc, fall_cyc, start_cyc;
    int runs, done_n, err_n, er_n, mism, idle_run;
    bit abort, finished, prev_en, seen_en, xfer;

    for (int i = 0; i < n; i++) payload.push_back(incr_data ? 8'(i) : 8'($urandom));
    // Reference frame built straight from the frame format rules.
    for (int i = 0; i < 7; i++) exp_q.push_back(8'h55);
    exp_q.push_back(8'hD5);
    h = {d, s, ty};
    for (int i = 0; i < 14; i++) exp_q.push_back(h[111 - 8*i -: 8]);
    abort = 1'b1;
    if (drop_at >= 0 && drop_at < n && drop_at < MAXP) pay_sent = drop_at;
    else if (n > MAXP)                                 pay_sent = MAXP;
    else if (!last_flag)                               pay_sent = n;
    else begin pay_sent = n; abort = 1'b0; end
    for (int i = 0; i < pay_sent; i++) exp_q.push_back(payload[i]);
    er_idx = -1;
    if (abort) begin
      exp_q.push_back(8'h00);
      er_idx = exp_q.size() - 1;
    end else begin
      for (int i = pay_sent; i < MINP; i++) exp_q.push_back(8'h00);
      c = 32'hFFFF_FFFF;
      for (int i = 8; i < exp_q.size(); i++) c = crc_upd(c, exp_q[i]);
      c = ~c;
      for (int i = 0; i < 4; i++) exp_q.push_back(c[8*i +: 8]);
    end

    idx = 0; xfers = 0; first_en = -1; last_en = -1; done_cyc = -1; fall_cyc = -1;
    runs = 0; done_n = 0; err_n = 0; idle_run = 0; finished = 0; prev_en = 0; seen_en = 0;
    @(posedge clk); #1;
    dst_mac = d; src_mac = s; eth_type = ty; start = 1'b1; start_cyc = cyc;
    pl_valid = (idx < n) && (idx != drop_at);
    pl_data  = (idx < n) ? payload[idx] : 8'h00;
    pl_last  = last_flag && (idx == n - 1);
    for (int t = 0; t < 4000; t++) begin
      @(negedge clk);
      if (!busy && t > 0) begin finished = 1; fall_cyc = cyc; break; end
      if (gmii_tx_en) begin
        got_q.push_back(gmii_tx_data);
        got_er.push_back(gmii_tx_er);
        if (!prev_en) runs++;
        if (first_en < 0) first_en = cyc;
        last_en = cyc; seen_en = 1; idle_run = 0;
      end else if (seen_en) begin
        idle_run++;
      end
      if (done) begin done_n++; done_cyc = cyc; end
      if (err) err_n++;
      xfer = pl_valid && pl_ready;
      prev_en = gmii_tx_en;
      @(posedge clk); #1;
      // Stray start requests during the frame and early IFG must be ignored.
      start = (prev_en || (seen_en && idle_run >= 1 && idle_run <= IFG - 3)) &&
              ($urandom_range(0, 3) == 0);
      if (xfer) begin idx++; xfers++; end
      pl_valid = (idx < n) && (idx != drop_at);
      pl_data  = (idx < n) ? payload[idx] : 8'h00;
      pl_last  = last_flag && (idx == n - 1);
    end
    start = 1'b0; pl_valid = 1'b0; pl_last = 1'b0;

    check({name, " finished"}, finished, 1'b1);
    check({name, " length"}, got_q.size(), exp_q.size());
    check({name, " contiguous"}, runs, 1);
    check({name, " latency"}, first_en - start_cyc, 1);
    check({name, " transfers"}, xfers, pay_sent);
    mism = 0; er_n = 0;
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      if (i != er_idx && got_q[i] !== exp_q[i]) mism++;
    foreach (got_er[i]) if (got_er[i]) er_n++;
    check({name, " byte_mismatches"}, mism, 0);
    check({name, " er_count"}, er_n, abort ? 1 : 0);
    if (abort && got_er.size() > 0) check({name, " er_last"}, got_er[got_er.size() - 1], 1'b1);
    check({name, " err_pulses"}, err_n, abort ? 1 : 0);
    check({name, " done_pulses"}, done_n, abort ? 0 : 1);
    check({name, " busy_fall"}, fall_cyc - last_en, IFG + 1);
    if (!abort) begin
      check({name, " done_pos"}, done_cyc - last_en, IFG);
      c = 32'hFFFF_FFFF;
      for (int i = 8; i < got_q.size(); i++) c = crc_upd(c, got_q[i]);
      rr = {<<{c}};  // residue is quoted in normal (non-reflected) bit order
      check({name, " residue"}, rr, 32'hC704_DD7B);
    end
  endtask

  task automatic reset_mid_frame();
    int idx, got_cnt, err_n;
    bit xfer;
    idx = 0; got_cnt = 0; err_n = 0;
    @(posedge clk); #1;
    start = 1'b1; dst_mac = 48'h0011_2233_4455; src_mac = 48'h6677_8899_AABB; eth_type = 16'h0800;
    pl_valid = 1'b1; pl_data = 8'hA5; pl_last = 1'b0;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (gmii_tx_en) got_cnt++;
      if (err) err_n++;
      if (got_cnt == 27) break;
      xfer = pl_valid && pl_ready;
      @(posedge clk); #1;
      start = 1'b0;
      if (xfer) idx++;
      pl_data = 8'(idx * 7);
    end
    check("rst reached payload byte 5", got_cnt, 27);
    #2 rst_n = 1'b0; pl_valid = 1'b0; start = 1'b0;
    #1 check("rst async outputs", all_outs(), 8'h00);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (err) err_n++;
    end
    check("rst no err", err_n, 0);
    check("rst idle busy", busy, 1'b0);
  endtask

  initial begin
    logic [31:0] t;
    int n, dp;
    for (int i = 0; i < 256; i++) begin
      t = 32'(i);
      for (int k = 0; k < 8; k++) t = t[0] ? ((t >> 1) ^ 32'hEDB8_8320) : (t >> 1);
      crc_tbl[i] = t;
    end
    rst_n = 1'b0; start = 1'b0; pl_valid = 1'b0; pl_last = 1'b0; pl_data = '0;
    dst_mac = '0; src_mac = '0; eth_type = '0;
    #12 check("reset outputs", all_outs(), 8'h00);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); @(negedge clk);
    check("phy_rst_n first flop", phy_rst_n, 1'b0);
    @(negedge clk);
    check("phy_rst_n second flop", phy_rst_n, 1'b1);
    check("idle outputs", {gmii_tx_en, gmii_tx_er, gmii_tx_data, pl_ready, busy}, '0);

    run_frame("pad10", 48'({$urandom(), $urandom()}), 48'({$urandom(), $urandom()}),
              16'($urandom), 10, 1, -1, 0);
    run_frame("inc100", 48'({$urandom(), $urandom()}), 48'({$urandom(), $urandom()}),
              16'h0800, 100, 1, -1, 1);
    run_frame("arp_hdr", 48'hFFFF_FFFF_FFFF, 48'h000A_3501_FEC0, 16'h0806, 50, 1, -1, 0);
    run_frame("underrun20", 48'({$urandom(), $urandom()}), 48'({$urandom(), $urandom()}),
              16'($urandom), 60, 1, 19, 0);
    run_frame("len45", 48'h1, 48'h2, 16'h3, 45, 1, -1, 0);
    run_frame("len46", 48'h1, 48'h2, 16'h3, 46, 1, -1, 0);
    run_frame("len47", 48'h1, 48'h2, 16'h3, 47, 1, -1, 0);
    run_frame("len1", 48'h4, 48'h5, 16'h6, 1, 1, -1, 0);
    for (int r = 0; r < 6; r++) begin
      n  = $urandom_range(1, 120);
      dp = ($urandom_range(0, 2) == 0) ? $urandom_range(0, n - 1) : -1;
      run_frame($sformatf("rand%0d", r), 48'({$urandom(), $urandom()}),
                48'({$urandom(), $urandom()}), 16'($urandom), n, 1, dp, 0);
    end
    reset_mid_frame();
    run_frame("after_reset", 48'({$urandom(), $urandom()}), 48'({$urandom(), $urandom()}),
              16'($urandom), 20, 1, -1, 0);
    run_frame("overlength", 48'({$urandom(), $urandom()}), 48'({$urandom(), $urandom()}),
              16'($urandom), MAXP + 1, 0, -1, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
